alu_compare_monitor: RTL and testbench

Response-side checker for the ALU verification flow: consumes the result streams of the reference ALU model and the synthesized ALU that are driven with identical stimulus, compares them every valid cycle, keeps transaction and mismatch counters, latches the first mismatching transaction, and after end-of-stimulus streams a fixed five-word report out over a valid/ready handshake. Synthesizable; sits beside the two ALU instances so the comparison can also run on hardware.

---
 rtl/alu_compare_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_compare_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_compare_monitor.sv
// Compares reference and synthesized ALU result streams, counts transactions and mismatches,
// captures the first mismatch, and streams a five-word report after end-of-stimulus.
module alu_compare_monitor #(
    parameter int BITS  = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [1:0]       i_op,
    input  logic [BITS-1:0]  i_a,
    input  logic [BITS-1:0]  i_b,
    input  logic [BITS-1:0]  i_out_ref,
    input  logic [BITS-1:0]  i_out_dut,
    input  logic [3:0]       i_status_ref,
    input  logic [3:0]       i_status_dut,
    input  logic             i_done,
    output logic             o_mismatch,
    output logic             o_rpt_valid,
    output logic [CNT_W-1:0] o_rpt_data,
    input  logic             i_rpt_ready,
    output logic             o_done,
    output logic             o_pass
);

    typedef enum logic [1:0] {
        S_COLLECT  = 2'b00,
        S_REPORT   = 2'b01,
        S_FINISHED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    function automatic logic [CNT_W-1:0] word_sel(
        input logic [2:0]       idx,
        input logic [CNT_W-1:0] txn,
        input logic [CNT_W-1:0] mis,
        input logic             seen,
        input logic [1:0]       op,
        input logic [BITS-1:0]  a,
        input logic [BITS-1:0]  b,
        input logic [BITS-1:0]  oref,
        input logic [BITS-1:0]  odut,
        input logic [3:0]       sref,
        input logic [3:0]       sdut
    );
        logic [CNT_W-1:0] w;
        case (idx)
            3'd0:    w = txn;
            3'd1:    w = mis;
            3'd2:    w = seen ? CNT_W'({a, b})          : '0;
            3'd3:    w = seen ? CNT_W'({oref, odut})    : '0;
            3'd4:    w = seen ? CNT_W'({op, sref, sdut}) : '0;
            default: w = '0;
        endcase
        return w;
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_txn_cnt;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic              r_first_seen;
    logic [1:0]        r_first_op;
    logic [BITS-1:0]   r_first_a;
    logic [BITS-1:0]   r_first_b;
    logic [BITS-1:0]   r_first_out_ref;
    logic [BITS-1:0]   r_first_out_dut;
    logic [3:0]        r_first_st_ref;
    logic [3:0]        r_first_st_dut;
    logic [2:0]        r_idx;
    logic              r_mismatch;
    logic              r_rpt_valid;
    logic [CNT_W-1:0]  r_rpt_data;
    logic              r_done;
    logic              r_pass;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_txn_nxt;
    logic [CNT_W-1:0]  w_mis_nxt;
    logic              w_seen_nxt;
    logic [1:0]        w_op_nxt;
    logic [BITS-1:0]   w_a_nxt;
    logic [BITS-1:0]   w_b_nxt;
    logic [BITS-1:0]   w_oref_nxt;
    logic [BITS-1:0]   w_odut_nxt;
    logic [3:0]        w_sref_nxt;
    logic [3:0]        w_sdut_nxt;
    logic [2:0]        w_idx_nxt;
    logic              w_mismatch_nxt;
    logic              w_rpt_valid_nxt;
    logic [CNT_W-1:0]  w_rpt_data_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic              w_is_mis;

    assign w_is_mis = (i_out_ref != i_out_dut) || (i_status_ref != i_status_dut);

    // Next-state computation for FSM, counters, first-mismatch capture and report outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_txn_nxt      = r_txn_cnt;
        w_mis_nxt      = r_mis_cnt;
        w_seen_nxt     = r_first_seen;
        w_op_nxt       = r_first_op;
        w_a_nxt        = r_first_a;
        w_b_nxt        = r_first_b;
        w_oref_nxt     = r_first_out_ref;
        w_odut_nxt     = r_first_out_dut;
        w_sref_nxt     = r_first_st_ref;
        w_sdut_nxt     = r_first_st_dut;
        w_idx_nxt      = r_idx;
        w_mismatch_nxt = 1'b0;

        case (r_state)
            S_COLLECT: begin
                if (i_valid) begin
                    w_txn_nxt = sat_inc(r_txn_cnt);
                    if (w_is_mis) begin
                        w_mis_nxt      = sat_inc(r_mis_cnt);
                        w_mismatch_nxt = 1'b1;
                        if (!r_first_seen) begin
                            w_seen_nxt = 1'b1;
                            w_op_nxt   = i_op;
                            w_a_nxt    = i_a;
                            w_b_nxt    = i_b;
                            w_oref_nxt = i_out_ref;
                            w_odut_nxt = i_out_dut;
                            w_sref_nxt = i_status_ref;
                            w_sdut_nxt = i_status_dut;
                        end else begin
                            w_seen_nxt = r_first_seen;
                        end
                    end else begin
                        w_mismatch_nxt = 1'b0;
                    end
                end else begin
                    w_txn_nxt = r_txn_cnt;
                end
                // A transaction in the same cycle as i_done is still counted above
                if (i_done) begin
                    w_state_nxt = S_REPORT;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_REPORT: begin
                if (r_rpt_valid && i_rpt_ready) begin
                    if (r_idx == 3'd4) begin
                        w_state_nxt = S_FINISHED;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            S_FINISHED: begin
                w_state_nxt = S_FINISHED;
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase

        w_rpt_valid_nxt = (w_state_nxt == S_REPORT);
        if (w_rpt_valid_nxt) begin
            w_rpt_data_nxt = word_sel(w_idx_nxt, w_txn_nxt, w_mis_nxt, w_seen_nxt, w_op_nxt,
                                      w_a_nxt, w_b_nxt, w_oref_nxt, w_odut_nxt,
                                      w_sref_nxt, w_sdut_nxt);
        end else begin
            w_rpt_data_nxt = '0;
        end
        w_done_nxt = (w_state_nxt == S_FINISHED);
        w_pass_nxt = w_done_nxt && (w_mis_nxt == '0);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_COLLECT;
            r_txn_cnt       <= '0;
            r_mis_cnt       <= '0;
            r_first_seen    <= 1'b0;
            r_first_op      <= 2'b00;
            r_first_a       <= '0;
            r_first_b       <= '0;
            r_first_out_ref <= '0;
            r_first_out_dut <= '0;
            r_first_st_ref  <= 4'h0;
            r_first_st_dut  <= 4'h0;
            r_idx           <= 3'd0;
            r_mismatch      <= 1'b0;
            r_rpt_valid     <= 1'b0;
            r_rpt_data      <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_txn_cnt       <= w_txn_nxt;
            r_mis_cnt       <= w_mis_nxt;
            r_first_seen    <= w_seen_nxt;
            r_first_op      <= w_op_nxt;
            r_first_a       <= w_a_nxt;
            r_first_b       <= w_b_nxt;
            r_first_out_ref <= w_oref_nxt;
            r_first_out_dut <= w_odut_nxt;
            r_first_st_ref  <= w_sref_nxt;
            r_first_st_dut  <= w_sdut_nxt;
            r_idx           <= w_idx_nxt;
            r_mismatch      <= w_mismatch_nxt;
            r_rpt_valid     <= w_rpt_valid_nxt;
            r_rpt_data      <= w_rpt_data_nxt;
            r_done          <= w_done_nxt;
            r_pass          <= w_pass_nxt;
        end
    end

    assign o_mismatch  = r_mismatch;
    assign o_rpt_valid = r_rpt_valid;
    assign o_rpt_data  = r_rpt_data;
    assign o_done      = r_done;
    assign o_pass      = r_pass;

endmodule

// File: tb/tb_alu_compare_monitor.sv
// Randomized scenario bench for alu_compare_monitor, checked against a transaction-level model.
module tb_alu_compare_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, done = 1'b0, rdy = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a = 8'h00, b = 8'h00, oref = 8'h00, odut = 8'h00;
    logic [3:0]  sref = 4'h0, sdut = 4'h0;
    logic        mism, rvalid, odone, opass;
    logic [15:0] rdata;

    logic        s_valid = 1'b0, s_done = 1'b0, s_rdy = 1'b0;
    logic [1:0]  s_op = 2'b00;
    logic [3:0]  s_a = 4'h0, s_b = 4'h0, s_oref = 4'h0, s_odut = 4'h0, s_sref = 4'h0, s_sdut = 4'h0;
    logic        s_mism, s_rvalid, s_odone, s_opass;
    logic [9:0]  s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int m_txn, m_mis, m_op, m_a, m_b, m_or, m_od, m_sr, m_sd;
    bit m_seen;

    always #5 clk = ~clk;

    alu_compare_monitor #(.BITS(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op(op), .i_a(a), .i_b(b),
        .i_out_ref(oref), .i_out_dut(odut), .i_status_ref(sref), .i_status_dut(sdut),
        .i_done(done), .o_mismatch(mism), .o_rpt_valid(rvalid), .o_rpt_data(rdata),
        .i_rpt_ready(rdy), .o_done(odone), .o_pass(opass)
    );

    alu_compare_monitor #(.BITS(4), .CNT_W(10)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .i_op(s_op), .i_a(s_a), .i_b(s_b),
        .i_out_ref(s_oref), .i_out_dut(s_odut), .i_status_ref(s_sref), .i_status_dut(s_sdut),
        .i_done(s_done), .o_mismatch(s_mism), .o_rpt_valid(s_rvalid), .o_rpt_data(s_rdata),
        .i_rpt_ready(s_rdy), .o_done(s_odone), .o_pass(s_opass)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_txn = 0; m_mis = 0; m_seen = 1'b0;
        m_op = 0; m_a = 0; m_b = 0; m_or = 0; m_od = 0; m_sr = 0; m_sd = 0;
    endtask

    function automatic int exp_word(input int k);
        case (k)
            0:       return (m_txn > 65535) ? 65535 : m_txn;
            1:       return (m_mis > 65535) ? 65535 : m_mis;
            2:       return m_seen ? (m_a * 256 + m_b) : 0;
            3:       return m_seen ? (m_or * 256 + m_od) : 0;
            4:       return m_seen ? (m_op * 256 + m_sr * 16 + m_sd) : 0;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; done = 1'b0; rdy = 1'b0;
        s_valid = 1'b0; s_done = 1'b0; s_rdy = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic send(input logic [1:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                        input logic [7:0] t_or, input logic [7:0] t_od,
                        input logic [3:0] t_sr, input logic [3:0] t_sd, input bit t_done);
        bit exp_mis;
        valid = 1'b1; op = t_op; a = t_a; b = t_b; oref = t_or; odut = t_od;
        sref = t_sr; sdut = t_sd; done = t_done;
        step();
        exp_mis = (t_or != t_od) || (t_sr != t_sd);
        n_tests++;
        if (mism !== exp_mis) begin
            n_fail++;
            $display("FAIL mismatch_pulse: got %b expected %b", mism, exp_mis);
        end
        m_txn++;
        if (exp_mis) begin
            m_mis++;
            if (!m_seen) begin
                m_seen = 1'b1; m_op = int'(t_op); m_a = int'(t_a); m_b = int'(t_b);
                m_or = int'(t_or); m_od = int'(t_od); m_sr = int'(t_sr); m_sd = int'(t_sd);
            end
        end
        valid = 1'b0; done = 1'b0;
    endtask

    task automatic send_match(input logic [1:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b);
        logic [7:0] r;
        logic [3:0] s;
        r = t_a - t_b;
        s = 4'($urandom);
        send(t_op, t_a, t_b, r, r, s, s, 1'b0);
    endtask

    task automatic send_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // mode 0: always ready; 1: low 3 cycles on word 1 then random; 2: random
    task automatic read_report(input int mode);
        int k = 0;
        int lowcnt = 0;
        int cyc = 0;
        logic r;
        logic [15:0] e;
        while (k < 5 && cyc < 200) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1 && k == 1 && lowcnt < 3) begin r = 1'b0; lowcnt++; end
            else if (mode == 1 && k == 0) r = 1'b1;
            else r = 1'($urandom_range(0, 1));
            rdy = r;
            e = 16'(exp_word(k));
            n_tests++;
            if (rvalid !== 1'b1 || rdata !== e || odone !== 1'b0) begin
                n_fail++;
                $display("FAIL rpt_word%0d: valid=%b data=%h done=%b expected valid=1 data=%h done=0",
                         k, rvalid, rdata, odone, e);
            end
            step();
            if (r) k++;
            cyc++;
        end
        rdy = 1'b0;
        if (k < 5) begin
            n_fail++;
            $display("FAIL rpt_timeout: %0d words accepted, expected 5", k);
        end
        n_tests++;
        if (odone !== 1'b1 || rvalid !== 1'b0 || opass !== (m_mis == 0)) begin
            n_fail++;
            $display("FAIL rpt_end: done=%b valid=%b pass=%b expected done=1 valid=0 pass=%b",
                     odone, rvalid, opass, (m_mis == 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({mism, rvalid, rdata, odone, opass} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: mis=%b valid=%b data=%h done=%b pass=%b expected all 0",
                     mism, rvalid, rdata, odone, opass);
        end
        do_reset();
    endtask

    task automatic test_matching();
        do_reset();
        send_match(2'b00, 8'hD2, 8'hD5);
        send_match(2'b00, 8'hA9, 8'h9A);
        send_match(2'b00, 8'h07, 8'h40);
        send_match(2'b00, 8'h6F, 8'h18);
        send_match(2'b00, 8'h6F, 8'h18);
        send_done();
        read_report(0);
        valid = 1'b1; oref = 8'h01; odut = 8'h02; done = 1'b1;
        step(); step();
        valid = 1'b0; done = 1'b0;
        n_tests++;
        if (odone !== 1'b1 || opass !== 1'b1 || mism !== 1'b0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL finished_hold: done=%b pass=%b mis=%b valid=%b expected 1 1 0 0",
                     odone, opass, mism, rvalid);
        end
    endtask

    task automatic test_single_mismatch();
        do_reset();
        send_match(2'b10, 8'h11, 8'h01);
        send_match(2'b10, 8'h22, 8'h02);
        send(2'b10, 8'h03, 8'h81, 8'h06, 8'h07, 4'h2, 4'h2, 1'b0);
        send_match(2'b10, 8'h44, 8'h03);
        send_match(2'b10, 8'h55, 8'h04);
        send_done();
        read_report(0);
    endtask

    task automatic test_status_mismatch();
        do_reset();
        send_match(2'b11, 8'h10, 8'h02);
        send(2'b11, 8'hAA, 8'h01, 8'hAB, 8'hAB, 4'h0, 4'h1, 1'b0);
        send_match(2'b00, 8'h33, 8'h11);
        send(2'b01, 8'h5C, 8'h5D, 8'h00, 8'h80, 4'h3, 4'h3, 1'b0);
        send_done();
        read_report(2);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) send(2'b01, 8'($urandom), 8'($urandom), 8'h12, 8'h21, 4'h5, 4'hA, 1'b0);
            else send_match(2'($urandom), 8'($urandom), 8'($urandom));
        end
        send_done();
        read_report(1);
    endtask

    task automatic test_same_cycle_done();
        do_reset();
        send_match(2'b00, 8'h01, 8'h02);
        send_match(2'b01, 8'h03, 8'h04);
        send(2'b10, 8'h9C, 8'h3E, 8'h38, 8'h39, 4'h8, 4'h9, 1'b1);
        read_report(0);
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        do_reset();
        send_match(2'b00, 8'h10, 8'h20);
        send(2'b11, 8'h0F, 8'hF0, 8'h01, 8'h02, 4'h1, 4'h1, 1'b0);
        send_done();
        rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = 16'(exp_word(k));
            n_tests++;
            if (rvalid !== 1'b1 || rdata !== e) begin
                n_fail++;
                $display("FAIL areset_pre%0d: valid=%b data=%h expected valid=1 data=%h",
                         k, rvalid, rdata, e);
            end
            step();
        end
        rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mism, rvalid, rdata, odone, opass} !== 20'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: mis=%b valid=%b data=%h done=%b pass=%b expected all 0",
                     mism, rvalid, rdata, odone, opass);
        end
        step(); step();
        rst = 1'b0;
        model_reset();
        rdy = 1'b1;
        step();
        n_tests++;
        if (rvalid !== 1'b0 || odone !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_no_resume: valid=%b done=%b expected 0 0", rvalid, odone);
        end
        rdy = 1'b0;
        send_match(2'b00, 8'h31, 8'h13);
        send_match(2'b01, 8'h47, 8'h74);
        send_done();
        read_report(0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else if ($urandom_range(0, 3) == 0) begin
                send(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     4'($urandom), 4'($urandom), 1'b0);
            end else begin
                send_match(2'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        send_done();
        read_report(2);
    endtask

    task automatic test_saturation();
        int n = 1030;
        int e;
        do_reset();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_op    = (i == 0) ? 2'b01 : 2'($urandom);
            s_a     = (i == 0) ? 4'h5  : 4'($urandom);
            s_b     = (i == 0) ? 4'h3  : 4'($urandom);
            s_oref  = (i == 0) ? 4'h1  : 4'($urandom);
            s_odut  = ~s_oref;
            s_sref  = (i == 0) ? 4'h6  : 4'($urandom);
            s_sdut  = (i == 0) ? 4'h9  : 4'($urandom);
            step();
        end
        s_valid = 1'b0;
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        s_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0, 1:    e = 1023;
                2:       e = 5 * 16 + 3;
                3:       e = 1 * 16 + 14;
                default: e = 1 * 256 + 6 * 16 + 9;
            endcase
            n_tests++;
            if (s_rvalid !== 1'b1 || s_rdata !== 10'(e)) begin
                n_fail++;
                $display("FAIL sat_word%0d: valid=%b data=%0d expected valid=1 data=%0d",
                         k, s_rvalid, s_rdata, e);
            end
            step();
        end
        s_rdy = 1'b0;
        n_tests++;
        if (s_odone !== 1'b1 || s_opass !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_end: done=%b pass=%b expected 1 0", s_odone, s_opass);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_matching();
        test_single_mismatch();
        test_status_mismatch();
        test_backpressure();
        test_same_cycle_done();
        test_async_reset();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
